demultiplexer8_stream: RTL
==========================

// Module: demultiplexer8_stream
//
// PURPOSE
// - 1-to-8 streaming demultiplexer: routes each accepted input word to one of 8 output lanes chosen by sel.
// - Each lane has a one-entry holding register with a valid/ready handshake.
// - Fans a single producer (e.g. a writeback or response bus) out to eight independent consumers.
// - Lanes drain independently: a stalled lane blocks only inputs addressed to it.
//
// PARAMETERS
// - WIDTH  32  data width of the input and of each lane
//
// PORTS
// - clock      in   1          single clock; all state updates on posedge
// - reset_n    in   1          asynchronous, active-low reset
// - flush      in   1          synchronous clear of all lanes
// - in_valid   in   1          input word present
// - in_ready   out  1          input accepted this cycle when in_valid && in_ready
// - in_sel     in   3          destination lane, 0..7
// - in_data    in   WIDTH      input word
// - out_valid  out  8          lane i holds a word
// - out_ready  in   8          consumer i takes the word this cycle
// - out_data   out  8*WIDTH    lane i word at [i*WIDTH +: WIDTH]
// - stall_cnt  out  16         present only with DEMUX8_STALL_COUNT_EN
//
// BEHAVIOUR
// - Reset (reset_n low, asynchronous):
//   - out_valid = 0 and out_data = 0.
//   - stall_cnt = 0.
//   - A reset mid-transfer drops all held words.
// - Lane state per lane: EMPTY or FULL, where FULL means out_valid[i] = 1.
// - Combinational accept path: in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]).
//   - This is a combinational out_ready -> in_ready path.
//   - in_ready does not depend on in_valid.
// - Accept when in_valid && in_ready:
//   - lane in_sel loads in_data; out_valid[in_sel] = 1 next cycle.
//   - Latency is 1 cycle from accept to out_valid.
// - Drain when out_valid[i] && out_ready[i]:
//   - the lane becomes EMPTY next cycle, unless it is refilled in the same cycle.
// - Simultaneous drain and accept on the same lane:
//   - the new word replaces the old one and the lane stays FULL.
//   - This gives full throughput of 1 word/cycle per lane.
// - A drain on lane j and an accept on lane k != j are independent.
// - Any number of lanes may drain in the same cycle.
// - flush:
//   - all out_valid = 0 next cycle and in_ready = 0.
//   - flush wins over a same-cycle accept and over drains; the words are lost.
// - Held data:
//   - out_data of a lane is stable while out_valid=1 && out_ready=0.
//   - out_data of an EMPTY lane keeps its last value; it is don't-care to consumers.
// - in_sel is fully decoded; there is no illegal lane.
// - Inputs are sampled only when in_valid=1; in_sel and in_data are ignored otherwise.
//
// CONFIGURATION
// - DEMUX8_STALL_COUNT_EN defined:
//   - stall_cnt increments once per cycle with in_valid && !in_ready && !flush.
//   - It saturates at 16'hFFFF.
//   - It is cleared only by reset; flush does not clear it.
// - DEMUX8_STALL_COUNT_EN undefined:
//   - no stall_cnt port and no counter logic.
//   - All other behaviour is identical.
//
// TESTING
// - Reset:
//   - assert reset_n=0 mid-stream with lanes 2 and 5 FULL.
//   - Required: out_valid=8'h00 immediately, before the next clock edge.
//   - Required: out_data=0 and stall_cnt=0.
// - Routing:
//   - send sel=0..7 with data 32'hA0+sel, all out_ready=0.
//   - Required: out_valid=8'hFF after the 8th accept.
//   - Required: lane i data = 32'hA0+i.
// - Backpressure:
//   - lane 3 FULL with out_ready[3]=0; present sel=3 data=32'h55.
//   - Required: in_ready=0 and lane 3 keeps its old word.
//   - Then present sel=4: required in_ready=1 and the word accepted.
// - Same-lane pass-through:
//   - lane 1 FULL with 32'h11, out_ready[1]=1, accept sel=1 data=32'h22.
//   - Required: out_valid[1] stays 1 and the next-cycle lane-1 data = 32'h22.
// - Flush:
//   - lanes 0, 6 FULL; assert flush with in_valid=1 sel=2.
//   - Required: in_ready=0, out_valid=8'h00 next cycle, lane 2 not loaded.
// - Stall counter (EN defined):
//   - hold 5 blocked cycles on lane 7.
//   - Required: stall_cnt=5.
//   - Preload near saturation: required stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/demultiplexer8_stream.sv
// 1-to-8 streaming demultiplexer with a one-entry holding register per lane.
// Optional saturating stall counter is built when DEMUX8_STALL_COUNT_EN is defined.
module demultiplexer8_stream #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
`ifdef DEMUX8_STALL_COUNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic [8*WIDTH-1:0] out_data
);

    logic [7:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [8];
    logic [WIDTH-1:0] data_d [8];
    logic             accept;

    // A lane can take a word when empty or when it is draining this same cycle.
    assign in_ready = !flush && (!valid_q[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < 8; i++) begin
            data_d[i] = data_q[i];
            if (accept && (in_sel == i[2:0])) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end else if (valid_q[i] && out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q;

    for (genvar g = 0; g < 8; g++) begin : g_lane_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

`ifdef DEMUX8_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
